freecell_engine: RTL

- Parametrised FreeCell game engine: holds tableau, free cells and home foundations, and validates then commits one move per handshake.
- Deal is loaded at runtime through a load port, not fixed at elaboration.
- Sits between the move-sequencer/testbench driver and the win/score display logic.
- Adds to the previous generation: reset, flow control, error codes, column overflow protection and a move counter.

---
 rtl/freecell_pkg.sv | 40 ++++
 rtl/freecell_move_checker.sv | 60 ++++++
 rtl/freecell_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/freecell_pkg.sv
// rtl/freecell_pkg.sv - shared card, location, error and FSM definitions for the FreeCell engine
package freecell_pkg;

    localparam int IDX_W = 3;
    localparam int LOC_W = 2 + IDX_W;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    localparam logic [1:0] SUIT_H = 2'd0;
    localparam logic [1:0] SUIT_D = 2'd1;
    localparam logic [1:0] SUIT_S = 2'd2;
    localparam logic [1:0] SUIT_C = 2'd3;

    localparam logic [1:0] LOC_COL  = 2'd0;
    localparam logic [1:0] LOC_FREE = 2'd1;
    localparam logic [1:0] LOC_HOME = 2'd2;
    localparam logic [1:0] LOC_BAD  = 2'd3;

    localparam logic [2:0] ERR_OK           = 3'd0;
    localparam logic [2:0] ERR_BAD_SRC      = 3'd1;
    localparam logic [2:0] ERR_BAD_DST      = 3'd2;
    localparam logic [2:0] ERR_DST_OCCUPIED = 3'd3;
    localparam logic [2:0] ERR_RULE         = 3'd4;
    localparam logic [2:0] ERR_COL_FULL     = 3'd5;
    localparam logic [2:0] ERR_GAME_WON     = 3'd6;

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_COMMIT} state_t;

    function automatic logic is_red(card_t c);
        return (c.suit == SUIT_H) || (c.suit == SUIT_D);
    endfunction

    function automatic logic can_stack(card_t top, card_t card);
        return (is_red(top) != is_red(card)) && (top.rank == card.rank + 4'd1);
    endfunction

endpackage

// File: rtl/freecell_move_checker.sv
// rtl/freecell_move_checker.sv - combinational move legality check producing a prioritised error code
module freecell_move_checker
    import freecell_pkg::*;
#(
    parameter int NUM_COLS  = 8,
    parameter int NUM_FREE  = 4,
    parameter int COL_DEPTH = 20,
    parameter int HW        = 5
) (
    input  logic             win,
    input  logic [1:0]       src_type,
    input  logic [IDX_W-1:0] src_idx,
    input  logic [1:0]       dst_type,
    input  logic [IDX_W-1:0] dst_idx,
    input  logic [5:0]       src_card,
    input  logic [5:0]       dst_top,
    input  logic [HW-1:0]    dst_height,
    input  logic [15:0]      home_rank,
    output logic [2:0]       err
);
    localparam logic [3:0]    NCOL  = 4'(NUM_COLS);
    localparam logic [3:0]    NFREE = 4'(NUM_FREE);
    localparam logic [HW-1:0] FULL  = HW'(COL_DEPTH);

    card_t      src_c;
    card_t      dst_c;
    logic       src_in, dst_in, src_bad, dst_bad;
    logic [3:0] home_top;

    assign src_c    = src_card;
    assign dst_c    = dst_top;
    assign src_in   = (src_type == LOC_COL  && {1'b0, src_idx} < NCOL) ||
                      (src_type == LOC_FREE && {1'b0, src_idx} < NFREE);
    assign src_bad  = !src_in || (src_card == 6'd0);
    assign dst_in   = (dst_type == LOC_COL  && {1'b0, dst_idx} < NCOL) ||
                      (dst_type == LOC_FREE && {1'b0, dst_idx} < NFREE) ||
                      (dst_type == LOC_HOME);
    assign dst_bad  = !dst_in || dst_type == LOC_BAD ||
                      (dst_type == src_type && dst_idx == src_idx);
    assign home_top = home_rank[{src_c.suit, 2'b00} +: 4];

    always_comb begin
        err = ERR_OK;
        if (win)
            err = ERR_GAME_WON;
        else if (src_bad)
            err = ERR_BAD_SRC;
        else if (dst_bad)
            err = ERR_BAD_DST;
        else if (dst_type == LOC_FREE && dst_top != 6'd0)
            err = ERR_DST_OCCUPIED;
        else if (dst_type == LOC_COL && dst_height == FULL)
            err = ERR_COL_FULL;
        else if (dst_type == LOC_COL && dst_height != '0 && !can_stack(dst_c, src_c))
            err = ERR_RULE;
        else if (dst_type == LOC_HOME && src_c.rank != home_top + 4'd1)
            err = ERR_RULE;
    end

endmodule

// File: rtl/freecell_engine.sv
// rtl/freecell_engine.sv - FreeCell board storage, deal loading and three-state move FSM
module freecell_engine
    import freecell_pkg::*;
#(
    parameter int NUM_COLS   = 8,
    parameter int NUM_FREE   = 4,
    parameter int COL_DEPTH  = 20,
    parameter int MOVE_CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [2:0]            load_col,
    input  logic [5:0]            load_card,
    input  logic                  move_valid,
    output logic                  move_ready,
    input  logic [LOC_W-1:0]      move_src,
    input  logic [LOC_W-1:0]      move_dst,
    output logic                  move_done,
    output logic                  move_ok,
    output logic [2:0]            move_err,
    output logic [5:0]            move_card,
    output logic                  win,
    output logic [MOVE_CNT_W-1:0] move_count,
    output logic [15:0]           home_rank
);
    localparam int HW = $clog2(COL_DEPTH + 1);
    localparam int AW = (COL_DEPTH > 1) ? $clog2(COL_DEPTH) : 1;
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int FW = (NUM_FREE > 1) ? $clog2(NUM_FREE) : 1;
    localparam logic [3:0]    NCOL  = 4'(NUM_COLS);
    localparam logic [3:0]    NFREE = 4'(NUM_FREE);
    localparam logic [HW-1:0] FULL  = HW'(COL_DEPTH);

    logic [5:0]            col_q    [NUM_COLS][COL_DEPTH];
    logic [5:0]            col_d    [NUM_COLS][COL_DEPTH];
    logic [HW-1:0]         height_q [NUM_COLS];
    logic [HW-1:0]         height_d [NUM_COLS];
    logic [5:0]            free_q   [NUM_FREE];
    logic [5:0]            free_d   [NUM_FREE];
    logic [15:0]           home_q, home_d;
    state_t                state_q, state_d;
    logic [LOC_W-1:0]      src_q, src_d, dst_q, dst_d;
    logic [2:0]            err_q, err_d, merr_q, merr_d;
    logic [5:0]            card_q, card_d, mcard_q, mcard_d;
    logic                  done_q, done_d, ok_q, ok_d, win_q, win_d;
    logic [MOVE_CNT_W-1:0] cnt_q, cnt_d;

    logic [CW-1:0] lc, si, di;
    logic [FW-1:0] sf, df;
    logic          src_col_in, src_free_in, dst_col_in, dst_free_in;
    logic [5:0]    src_card, dst_top;
    logic [HW-1:0] dst_height;
    logic [2:0]    chk_err;

    assign lc = CW'(load_col);
    assign si = CW'(src_q[IDX_W-1:0]);
    assign di = CW'(dst_q[IDX_W-1:0]);
    assign sf = FW'(src_q[IDX_W-1:0]);
    assign df = FW'(dst_q[IDX_W-1:0]);
    assign src_col_in  = src_q[4:3] == LOC_COL  && {1'b0, src_q[IDX_W-1:0]} < NCOL;
    assign src_free_in = src_q[4:3] == LOC_FREE && {1'b0, src_q[IDX_W-1:0]} < NFREE;
    assign dst_col_in  = dst_q[4:3] == LOC_COL  && {1'b0, dst_q[IDX_W-1:0]} < NCOL;
    assign dst_free_in = dst_q[4:3] == LOC_FREE && {1'b0, dst_q[IDX_W-1:0]} < NFREE;

    // Out-of-range or empty locations read as card 0 so the checker sees them as empty.
    always_comb begin
        src_card   = '0;
        dst_top    = '0;
        dst_height = '0;
        if (src_col_in) begin
            if (height_q[si] != '0)
                src_card = col_q[si][AW'(height_q[si] - 1'b1)];
        end else if (src_free_in) begin
            src_card = free_q[sf];
        end
        if (dst_col_in) begin
            dst_height = height_q[di];
            if (height_q[di] != '0)
                dst_top = col_q[di][AW'(height_q[di] - 1'b1)];
        end else if (dst_free_in) begin
            dst_top = free_q[df];
        end
    end

    freecell_move_checker #(
        .NUM_COLS  (NUM_COLS),
        .NUM_FREE  (NUM_FREE),
        .COL_DEPTH (COL_DEPTH),
        .HW        (HW)
    ) u_checker (
        .win        (win_q),
        .src_type   (src_q[4:3]),
        .src_idx    (src_q[IDX_W-1:0]),
        .dst_type   (dst_q[4:3]),
        .dst_idx    (dst_q[IDX_W-1:0]),
        .src_card   (src_card),
        .dst_top    (dst_top),
        .dst_height (dst_height),
        .home_rank  (home_q),
        .err        (chk_err)
    );

    assign move_ready = (state_q == ST_IDLE) && !load_valid;

    always_comb begin
        col_d    = col_q;
        height_d = height_q;
        free_d   = free_q;
        home_d   = home_q;
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        err_d    = err_q;
        card_d   = card_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        ok_d     = 1'b0;
        merr_d   = ERR_OK;
        mcard_d  = '0;
        win_d    = win_q || (home_q == 16'hDDDD);
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    if ({1'b0, load_col} < NCOL && height_q[lc] != FULL && load_card != 6'd0) begin
                        col_d[lc][AW'(height_q[lc])] = load_card;
                        height_d[lc] = height_q[lc] + 1'b1;
                    end
                end else if (move_valid) begin
                    src_d   = move_src;
                    dst_d   = move_dst;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                err_d   = chk_err;
                card_d  = src_card;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                done_d  = 1'b1;
                ok_d    = (err_q == ERR_OK);
                merr_d  = err_q;
                mcard_d = card_q;
                state_d = ST_IDLE;
                if (err_q == ERR_OK) begin
                    if (src_q[4:3] == LOC_COL)
                        height_d[si] = height_q[si] - 1'b1;
                    else
                        free_d[sf] = '0;
                    if (dst_q[4:3] == LOC_COL) begin
                        col_d[di][AW'(height_q[di])] = card_q;
                        height_d[di] = height_q[di] + 1'b1;
                    end else if (dst_q[4:3] == LOC_FREE) begin
                        free_d[df] = card_q;
                    end else begin
                        home_d[{card_q[5:4], 2'b00} +: 4] = card_q[3:0];
                    end
                    if (cnt_q != '1)
                        cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                height_q[c] <= '0;
                for (int r = 0; r < COL_DEPTH; r++)
                    col_q[c][r] <= '0;
            end
            for (int f = 0; f < NUM_FREE; f++)
                free_q[f] <= '0;
            home_q  <= '0;
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            err_q   <= ERR_OK;
            card_q  <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            merr_q  <= ERR_OK;
            mcard_q <= '0;
            win_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            col_q    <= col_d;
            height_q <= height_d;
            free_q   <= free_d;
            home_q   <= home_d;
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            err_q    <= err_d;
            card_q   <= card_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            merr_q   <= merr_d;
            mcard_q  <= mcard_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
        end
    end

    assign move_done  = done_q;
    assign move_ok    = ok_q;
    assign move_err   = merr_q;
    assign move_card  = mcard_q;
    assign win        = win_q;
    assign move_count = cnt_q;
    assign home_rank  = home_q;

endmodule
